countdown_timer: RTL
====================

Name: countdown_timer

Overview:
- Four-digit mm:ss BCD countdown timer. It is the decrementing counterpart of the team's up-counting modulo digit counters.
- Loads a preset, decrements once per prescaled tick with a borrow chain across digits, and flags expiry with a one-cycle pulse.
- Sits between the button/command logic and the 7-segment display driver in the clock design.

Parameters:
- TICK_DIV, 100_000_000: clk cycles per decrement; must be ≥ 2.
- DIV_BITS, $clog2(TICK_DIV): prescaler width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- load  in  1  load load_data into digits; stops the timer
- load_data  in  16  BCD preset {min_tens, min_ones, sec_tens, sec_ones}, 4 bits each
- start  in  1  begin or resume counting
- stop  in  1  pause counting
- digits  out  16  current BCD value, same nibble order as load_data
- running  out  1  high while in RUN
- done  out  1  one-cycle pulse on reaching 0000

Behaviour:
- Reset is the synchronous rst (active-high) on clock clk. Reset values: digits = 0x0000, running = 0, done = 0, prescaler = 0, state = IDLE.
- Per-cycle priority: rst > load > stop > start > tick.
- Digit moduli: sec_ones 10, sec_tens 6, min_ones 10, min_tens 10. Maximum value is 0x9959.
- load, in any state:
  - Each nibble is written with clamping: a nibble ≥ its modulus is stored as modulus−1.
  - Prescaler clears to 0; next state is IDLE.
- States: IDLE, RUN, PAUSE, DONE.
  - IDLE: start with digits ≠ 0000 → RUN. start with digits = 0000 is ignored.
  - RUN: stop → PAUSE. Prescaler holds its value.
  - RUN: on a tick that makes digits 0000 → DONE.
  - PAUSE: start → RUN, prescaler resumes from its held value. stop has no effect.
  - DONE: start is ignored. stop → IDLE. load → IDLE.
- running = 1 exactly when the state is RUN (registered, same cycle as the state).
- Prescaler:
  - Counts 0..TICK_DIV−1 only in RUN.
  - A tick fires in the cycle where prescaler = TICK_DIV−1; the prescaler then wraps to 0.
  - The first decrement therefore lands TICK_DIV cycles after the start edge.
- Decrement on a tick:
  - sec_ones − 1. At 0 it wraps to 9 and borrows into sec_tens.
  - sec_tens wraps 0 → 5 and borrows into min_ones; min_ones wraps 0 → 9 and borrows into min_tens.
  - min_tens never underflows, because 0000 is never decremented.
  - digits updates in the same cycle as the tick, i.e. visible on the next edge.
- done:
  - Registered; high for exactly the one cycle in which digits first reads 0000 after a tick.
  - Not asserted by loading 0000, by reset, or while sitting in DONE.
- Simultaneous events:
  - stop and tick together: stop wins; no decrement; the prescaler still holds at TICK_DIV−1 and fires on resume.
  - load and start together: load wins; the state is IDLE.
- Reset mid-operation: all outputs go to their reset values on the next edge. A pending done pulse is suppressed.

Optional Feature:
- Macro: COUNTDOWN_AUTO_RELOAD_EN.
- When defined:
  - The last accepted (clamped) load value is kept in a shadow register (reset 0x0000).
  - On reaching 0000, done still pulses, but the state stays RUN and digits reloads from the shadow register on the next tick instead of decrementing.
  - If the shadow value is 0000, the timer enters DONE as normal.
- When undefined: no shadow register exists, and behaviour is exactly as above.

Decomposition:
- Package countdown_pkg:
  - state enum (IDLE, RUN, PAUSE, DONE)
  - digit width constant BCD_W = 4
  - modulus constants SEC_ONES_MOD = 10, SEC_TENS_MOD = 6, MIN_ONES_MOD = 10, MIN_TENS_MOD = 10
- Sub-module bcd_down_digit, instantiated four times:
  - Parameter MODULUS.
  - Inputs: clk, rst, load, load_val, dec.
  - Outputs: value, borrow_out (combinational: dec && value == 0).
  - The load clamp is inside the sub-module.
  - Chain: each digit's dec is the previous digit's borrow_out; sec_ones dec is the tick.

Test Plan (TICK_DIV = 4):
- Load 0x0002, start → digits 0x0001 at 4 cycles after start, 0x0000 at 8 cycles; done high exactly one cycle; running falls with DONE; a further start is ignored.
- Load 0x0100, start, one tick → 0x0059. Load 0x1000, one tick → 0x0959.
- Load 0x00F7 → digits 0x0057. Load 0xAAAA → 0x9959.
- Run from 0x0005. Assert stop after 2 cycles and hold it 10 cycles → digits and prescaler frozen, running = 0. Start → first decrement 2 cycles later (prescaler resumed).
- Load 0x0000, start → stays IDLE, no done. rst asserted mid-RUN → digits 0x0000, running 0, done 0 next edge.
- With COUNTDOWN_AUTO_RELOAD_EN: load 0x0002, start → done pulses at cycle 8, running stays 1, digits = 0x0002 at cycle 12.

Source files
------------

// File: rtl/countdown_pkg.sv
// Shared types and constants for the mm:ss BCD countdown timer.
// Digit moduli and the load clamp live here so every block agrees on them.
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_t;

  localparam int BCD_W = 4;

  localparam int SEC_ONES_MOD = 10;
  localparam int SEC_TENS_MOD = 6;
  localparam int MIN_ONES_MOD = 10;
  localparam int MIN_TENS_MOD = 10;

  function automatic logic [BCD_W-1:0] clamp_nib(
    input logic [BCD_W-1:0] n,
    input int               modulus
  );
    logic [BCD_W-1:0] top;
    top = BCD_W'(modulus - 1);
    return (n > top) ? top : n;
  endfunction

  // Clamp a packed {min_tens, min_ones, sec_tens, sec_ones} preset.
  function automatic logic [4*BCD_W-1:0] clamp_bcd(
    input logic [4*BCD_W-1:0] raw
  );
    logic [4*BCD_W-1:0] res;
    res[15:12] = clamp_nib(raw[15:12], MIN_TENS_MOD);
    res[11:8]  = clamp_nib(raw[11:8], MIN_ONES_MOD);
    res[7:4]   = clamp_nib(raw[7:4], SEC_TENS_MOD);
    res[3:0]   = clamp_nib(raw[3:0], SEC_ONES_MOD);
    return res;
  endfunction

endpackage

// File: rtl/countdown_timer_digit.sv
// One BCD down-counting digit with clamped load and borrow output.
// Borrow is combinational so a whole chain resolves in one cycle.
module bcd_down_digit
  import countdown_pkg::*;
#(
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [BCD_W-1:0] load_val,
  input  logic             dec,
  output logic [BCD_W-1:0] value,
  output logic             borrow_out
);

  localparam logic [BCD_W-1:0] MAX = BCD_W'(MODULUS - 1);

  assign borrow_out = dec && (value == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= (load_val > MAX) ? MAX : load_val;
    end else if (dec) begin
      value <= (value == '0) ? MAX : value - BCD_W'(1);
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Four-digit mm:ss BCD countdown with prescaler and one-cycle expiry pulse.
// Define COUNTDOWN_AUTO_RELOAD_EN to restart from the last preset on expiry.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000,
  parameter int DIV_BITS = $clog2(TICK_DIV)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_data,
  input  logic        start,
  input  logic        stop,
  output logic [15:0] digits,
  output logic        running,
  output logic        done
);

  localparam logic [DIV_BITS-1:0] PRESC_TOP =
    DIV_BITS'(TICK_DIV - 1);

  state_t              state;
  logic [DIV_BITS-1:0] presc;

  logic        tick;
  logic        at_zero;
  logic        last_step;
  logic        reload;
  logic        hold_run;
  logic        digit_load;
  logic [15:0] digit_val;
  logic [2:0]  borrow;
  logic        unused_borrow;

  assign at_zero   = (digits == 16'h0000);
  assign last_step = (digits == 16'h0001);

  // stop and load both outrank the tick, so gate them here.
  assign tick = (state == RUN) && !load && !stop &&
                (presc == PRESC_TOP);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [15:0] shadow;

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
    end else if (load) begin
      shadow <= clamp_bcd(load_data);
    end
  end

  assign reload    = tick && at_zero;
  assign hold_run  = (shadow != '0);
  assign digit_val = load ? load_data : shadow;
`else
  assign reload    = 1'b0;
  assign hold_run  = 1'b0;
  assign digit_val = load_data;
`endif

  assign digit_load = load || reload;

  bcd_down_digit #(
    .MODULUS(SEC_ONES_MOD)
  ) u_sec_ones (
    .clk       (clk),
    .rst       (rst),
    .load      (digit_load),
    .load_val  (digit_val[3:0]),
    .dec       (tick && !reload),
    .value     (digits[3:0]),
    .borrow_out(borrow[0])
  );

  bcd_down_digit #(
    .MODULUS(SEC_TENS_MOD)
  ) u_sec_tens (
    .clk       (clk),
    .rst       (rst),
    .load      (digit_load),
    .load_val  (digit_val[7:4]),
    .dec       (borrow[0]),
    .value     (digits[7:4]),
    .borrow_out(borrow[1])
  );

  bcd_down_digit #(
    .MODULUS(MIN_ONES_MOD)
  ) u_min_ones (
    .clk       (clk),
    .rst       (rst),
    .load      (digit_load),
    .load_val  (digit_val[11:8]),
    .dec       (borrow[1]),
    .value     (digits[11:8]),
    .borrow_out(borrow[2])
  );

  // 0000 is never decremented, so the top borrow never fires.
  bcd_down_digit #(
    .MODULUS(MIN_TENS_MOD)
  ) u_min_tens (
    .clk       (clk),
    .rst       (rst),
    .load      (digit_load),
    .load_val  (digit_val[15:12]),
    .dec       (borrow[2]),
    .value     (digits[15:12]),
    .borrow_out(unused_borrow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      running <= 1'b0;
      done    <= 1'b0;
      presc   <= '0;
    end else begin
      done <= 1'b0;
      if (load) begin
        state   <= IDLE;
        running <= 1'b0;
        presc   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (!stop && start && !at_zero) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          RUN: begin
            if (stop) begin
              state   <= PAUSE;
              running <= 1'b0;
            end else if (tick) begin
              presc <= '0;
              if (last_step) begin
                done <= 1'b1;
                if (!hold_run) begin
                  state   <= DONE;
                  running <= 1'b0;
                end
              end
            end else begin
              presc <= presc + DIV_BITS'(1);
            end
          end
          PAUSE: begin
            if (!stop && start) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          DONE: begin
            if (stop) begin
              state <= IDLE;
            end
          end
          default: begin
            state   <= IDLE;
            running <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
